// File: rtl/oc_allocator.sv
// oc_allocator: round-robin output-channel allocator; each output is held by one VC
// from header grant until that VC's tail flit is accepted downstream.
module oc_allocator #(
  parameter int IN_N  = 5,
  parameter int OUT_M = 5,
  parameter int IN_W  = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IN_N*OUT_M-1:0] req_i,
  input  logic [IN_N-1:0]       vld_i,
  input  logic [IN_N-1:0]       tail_i,
  input  logic [OUT_M-1:0]      oc_rdy_i,
  output logic [IN_N-1:0]       grant_o,
  output logic [OUT_M*IN_W-1:0] sel_o,
  output logic [OUT_M-1:0]      sel_vld_o
);
  localparam logic [0:0] FREE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]      st   [OUT_M];
  logic [IN_W-1:0] own  [OUT_M];
  logic [IN_W-1:0] ptr  [OUT_M];
  logic [IN_W-1:0] win  [OUT_M];
  logic [IN_N-1:0] elig [OUT_M];
  logic [OUT_M-1:0] avail [IN_N];
  logic [OUT_M-1:0] ffo   [IN_N];
  logic [OUT_M-1:0] busy, any, rel;

  function automatic logic [IN_W-1:0] nxt(input logic [IN_W-1:0] p, input int k);
    return IN_W'((int'(p) + k) % IN_N);
  endfunction

  always_comb begin
    for (int o = 0; o < OUT_M; o++) busy[o] = (st[o] == BUSY);
  end

  always_comb begin
    grant_o = '0;
    for (int o = 0; o < OUT_M; o++)
      for (int i = 0; i < IN_N; i++)
        if (busy[o] && own[o] == IN_W'(i)) grant_o[i] = 1'b1;
  end

  // a multi-hot request only competes for its lowest-indexed free output
  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      avail[i] = req_i[i*OUT_M +: OUT_M] & ~busy;
      ffo[i]   = avail[i] & (~avail[i] + 1'b1);
    end
    for (int o = 0; o < OUT_M; o++)
      for (int i = 0; i < IN_N; i++)
        elig[o][i] = ffo[i][o] & ~grant_o[i];
  end

  always_comb begin
    for (int o = 0; o < OUT_M; o++) begin
      any[o] = 1'b0;
      win[o] = ptr[o];
      for (int k = 1; k <= IN_N; k++)
        if (!any[o] && elig[o][nxt(ptr[o], k)]) begin
          any[o] = 1'b1;
          win[o] = nxt(ptr[o], k);
        end
      rel[o] = busy[o] & vld_i[own[o]] & tail_i[own[o]] & oc_rdy_i[o];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int o = 0; o < OUT_M; o++) begin
        st[o]  <= FREE;
        own[o] <= '0;
        ptr[o] <= IN_W'(IN_N - 1);
      end
    end else begin
      for (int o = 0; o < OUT_M; o++)
        if (busy[o]) begin
          if (rel[o]) st[o] <= FREE;
        end else if (any[o]) begin
          st[o]  <= BUSY;
          own[o] <= win[o];
          ptr[o] <= win[o];
        end
    end
  end

  always_comb begin
    sel_o = '0;
    for (int o = 0; o < OUT_M; o++) sel_o[o*IN_W +: IN_W] = busy[o] ? own[o] : '0;
  end

  assign sel_vld_o = busy;
endmodule

// File: tb/tb_oc_allocator.sv
// tb_oc_allocator: directed scenarios plus random traffic, checked each cycle
// against an integer-level ownership model of the allocator.
module tb_oc_allocator;
  localparam int N = 5;
  localparam int M = 5;
  localparam int W = 3;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N*M-1:0] req = '0;
  logic [N-1:0]  vld = '0, tail = '0, grant;
  logic [M-1:0]  rdy = '0, sel_vld;
  logic [M*W-1:0] sel;

  int n_checks = 0;
  int n_err = 0;

  int m_own [M];
  bit m_busy [M];
  int m_ptr [M];

  oc_allocator #(.IN_N(N), .OUT_M(M)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .vld_i(vld), .tail_i(tail),
    .oc_rdy_i(rdy), .grant_o(grant), .sel_o(sel), .sel_vld_o(sel_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sel_of(input int o);
    return int'((sel >> (o * W)) & 15'h7);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < M; o++) begin
      m_busy[o] = 0;
      m_own[o] = 0;
      m_ptr[o] = N - 1;
    end
  endtask

  function automatic bit owns(input int i);
    for (int o = 0; o < M; o++) if (m_busy[o] && m_own[o] == i) return 1;
    return 0;
  endfunction

  function automatic int lowest_free(input int i);
    for (int p = 0; p < M; p++) if (req[i*M+p] && !m_busy[p]) return p;
    return -1;
  endfunction

  task automatic model_step();
    bit nb [M];
    int no [M];
    int np [M];
    for (int o = 0; o < M; o++) begin
      nb[o] = m_busy[o];
      no[o] = m_own[o];
      np[o] = m_ptr[o];
      if (m_busy[o]) begin
        if (vld[m_own[o]] && tail[m_own[o]] && rdy[o]) nb[o] = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr[o] + k) % N;
          if (!nb[o] && !owns(c) && lowest_free(c) == o) begin
            nb[o] = 1;
            no[o] = c;
            np[o] = c;
          end
        end
      end
    end
    for (int o = 0; o < M; o++) begin
      m_busy[o] = nb[o];
      m_own[o] = no[o];
      m_ptr[o] = np[o];
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    logic [M-1:0] ev;
    logic [M*W-1:0] es;
    eg = '0;
    ev = '0;
    es = '0;
    for (int o = 0; o < M; o++)
      if (m_busy[o]) begin
        eg[m_own[o]] = 1'b1;
        ev[o] = 1'b1;
        es[o*W +: W] = W'(m_own[o]);
      end
    check("grant", 32'(grant), 32'(eg));
    check("sel_vld", 32'(sel_vld), 32'(ev));
    check("sel", 32'(sel), 32'(es));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_ni) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic set_req(input int i, input int o);
    req[i*M+o] = 1'b1;
  endtask

  initial begin
    int order [$];
    bit prev;
    model_reset();
    #3;
    check("rst_grant", 32'(grant), 0);
    check("rst_sel_vld", 32'(sel_vld), 0);
    check("rst_sel", 32'(sel), 0);
    tick();
    tick();
    rst_ni = 1'b1;

    // input 0 claims output 2, holds through body flits, tail held off by rdy
    set_req(0, 2);
    tick();
    check("g0_grant", 32'(grant), 32'h01);
    check("g0_vld", 32'(sel_vld), 32'h04);
    check("g0_sel2", 32'(sel_of(2)), 0);
    vld = 5'b00001;
    rdy = '1;
    for (int c = 0; c < 3; c++) tick();
    check("body_hold", 32'(sel_vld), 32'h04);
    tail = 5'b00001;
    rdy = 5'b11011;
    tick();
    check("tail_nordy", 32'(sel_vld), 32'h04);
    rdy = '1;
    req = '0;
    tick();
    check("tail_rel_vld", 32'(sel_vld), 0);
    check("tail_rel_grant", 32'(grant), 0);

    // three contenders for output 1, each packet is a single header+tail
    set_req(1, 1);
    set_req(3, 1);
    set_req(4, 1);
    vld = '1;
    tail = '1;
    prev = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (sel_vld[1] && !prev) order.push_back(sel_of(1));
      prev = sel_vld[1];
    end
    check("rr_count", 32'(order.size() >= 4), 1);
    for (int k = 0; k < 4; k++)
      check("rr_order", 32'(k < order.size() ? order[k] : 99), (k == 0 || k == 3) ? 1 : (k == 1 ? 3 : 4));
    req = '0;
    tick();
    tick();

    // two disjoint grants in the same cycle
    vld = '0;
    tail = '0;
    set_req(0, 0);
    set_req(1, 4);
    tick();
    check("dual_grant", 32'(grant), 32'h03);
    check("dual_vld", 32'(sel_vld), 32'h11);
    check("dual_sel4", 32'(sel_of(4)), 1);
    req = '0;
    vld = 5'b00011;
    tail = 5'b00011;
    tick();
    vld = '0;
    tail = '0;
    tick();

    // multi-hot input takes only its lowest free output
    set_req(2, 1);
    set_req(2, 2);
    tick();
    check("mh_vld", 32'(sel_vld), 32'h02);
    check("mh_grant", 32'(grant), 32'h04);
    set_req(3, 2);
    tick();
    check("mh_other_vld", 32'(sel_vld), 32'h06);
    check("mh_other_sel2", 32'(sel_of(2)), 3);
    set_req(0, 0);
    tick();
    check("three_busy", 32'(sel_vld), 32'h07);

    // async reset mid-cycle clears everything immediately
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("arst_grant", 32'(grant), 0);
    check("arst_vld", 32'(sel_vld), 0);
    check("arst_sel", 32'(sel), 0);
    req = '0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 3);
    tick();
    check("post_rst_sel3", 32'(sel_of(3)), 0);
    check("post_rst_grant", 32'(grant), 32'h01);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 9);
        req[i*M +: M] = (r < 6) ? M'(1 << $urandom_range(0, M - 1)) : (r < 8 ? M'($urandom) : '0);
      end
      vld = N'($urandom);
      tail = N'($urandom) & N'($urandom);
      rdy = M'($urandom) | M'($urandom);
      tick();
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("rnd_arst", 32'({grant, sel_vld}), 0);
        rst_ni = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
